board_ram_arbiter: RTL and testbench

Arbiter and sequencer for the shared 8x8 checkerboard state RAM (64 × 2-bit, one read port, one write port). It multiplexes two read requesters onto the single read port: the LED scanner and the game judger. It also multiplexes two write requesters onto the single write port: the memory-clear engine and the move writer. It returns read data with a tagged valid strobe. It sits between those clients and `checkerboard_state_ram`, replacing the state-driven muxes in the game top level.

---
 rtl/board_ram_arbiter_if.sv | 53 +++++
 rtl/board_ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_ram_arbiter_if.sv
// Bus bundle between the board-RAM clients, the RAM and board_ram_arbiter.
// slave = arbiter side, master = clients plus RAM side.
interface board_ram_arbiter_if #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 2
);
  logic                 s_req;
  logic [ADDR_BITS-1:0] s_addr;
  logic                 s_gnt;
  logic                 s_rvalid;
  logic [DATA_BITS-1:0] s_rdata;

  logic                 j_req;
  logic [ADDR_BITS-1:0] j_addr;
  logic                 j_gnt;
  logic                 j_rvalid;
  logic [DATA_BITS-1:0] j_rdata;

  logic                 c_req;
  logic [ADDR_BITS-1:0] c_addr;
  logic [DATA_BITS-1:0] c_data;
  logic                 c_gnt;

  logic                 m_req;
  logic [ADDR_BITS-1:0] m_addr;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_gnt;

  logic [ADDR_BITS-1:0] ram_rd_addr;
  logic [DATA_BITS-1:0] ram_rd_data;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_wr_addr;
  logic [DATA_BITS-1:0] ram_wr_data;
  logic [3:0]           starve_cnt;

  modport slave (
    input  s_req, s_addr, j_req, j_addr,
    input  c_req, c_addr, c_data, m_req, m_addr, m_data,
    input  ram_rd_data,
    output s_gnt, s_rvalid, s_rdata, j_gnt, j_rvalid, j_rdata,
    output c_gnt, m_gnt,
    output ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data, starve_cnt
  );

  modport master (
    output s_req, s_addr, j_req, j_addr,
    output c_req, c_addr, c_data, m_req, m_addr, m_data,
    output ram_rd_data,
    input  s_gnt, s_rvalid, s_rdata, j_gnt, j_rvalid, j_rdata,
    input  c_gnt, m_gnt,
    input  ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data, starve_cnt
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Read/write arbiter for the shared 64x2 board state RAM with tagged read return.
// Optional build macro BOARD_ARB_FWD_EN: same-cycle write-to-read forwarding.
module board_ram_arbiter #(
  parameter int ADDR_BITS   = 6,
  parameter int DATA_BITS   = 2,
  parameter int JUDGER_PRIO = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  board_ram_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_S = 1'b0,
    LAST_J = 1'b1
  } who_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] STARVE_SAT = 4'd15;

  logic                 c_gnt_s;
  logic                 m_gnt_s;
  logic                 we_s;
  logic [ADDR_BITS-1:0] wr_addr_s;
  logic [DATA_BITS-1:0] wr_data_s;

  logic                 s_gnt_s;
  logic                 j_gnt_s;
  logic                 rd_gnt_s;
  logic [DATA_BITS-1:0] rd_src_s;

  who_e                 last_q, last_d;
  logic [3:0]           starve_q, starve_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 tag_valid_q, tag_valid_d;
  who_e                 tag_who_q, tag_who_d;

  // Write port: clear engine strictly ahead of the move writer.
  always_comb begin
    c_gnt_s   = bus.c_req;
    m_gnt_s   = bus.m_req & ~bus.c_req;
    we_s      = c_gnt_s | m_gnt_s;
    wr_addr_s = '0;
    wr_data_s = '0;
    if (c_gnt_s) begin
      wr_addr_s = bus.c_addr;
      wr_data_s = bus.c_data;
    end else if (m_gnt_s) begin
      wr_addr_s = bus.m_addr;
      wr_data_s = bus.m_data;
    end else begin
      wr_addr_s = '0;
      wr_data_s = '0;
    end
  end

  // Read port arbitration, starvation counter, read-address hold and return tag.
  always_comb begin
    s_gnt_s = 1'b0;
    j_gnt_s = 1'b0;
    if (bus.c_req) begin
      s_gnt_s = 1'b0;
      j_gnt_s = 1'b0;
    end else if (JUDGER_PRIO != 0) begin
      // Denials can overshoot MAX_WAIT while a clear blocks reads; >= keeps the scanner live.
      if (bus.s_req && (starve_q >= MAX_WAIT_C)) begin
        s_gnt_s = 1'b1;
      end else if (bus.j_req) begin
        j_gnt_s = 1'b1;
      end else if (bus.s_req) begin
        s_gnt_s = 1'b1;
      end else begin
        s_gnt_s = 1'b0;
      end
    end else begin
      if (bus.s_req && bus.j_req) begin
        if (last_q == LAST_S) begin
          j_gnt_s = 1'b1;
        end else begin
          s_gnt_s = 1'b1;
        end
      end else if (bus.s_req) begin
        s_gnt_s = 1'b1;
      end else if (bus.j_req) begin
        j_gnt_s = 1'b1;
      end else begin
        s_gnt_s = 1'b0;
      end
    end

    rd_gnt_s = s_gnt_s | j_gnt_s;

    starve_d = 4'd0;
    if ((JUDGER_PRIO != 0) && bus.s_req && !s_gnt_s) begin
      starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end

    last_d    = last_q;
    rd_addr_d = rd_addr_q;
    if (s_gnt_s) begin
      last_d    = LAST_S;
      rd_addr_d = bus.s_addr;
    end else if (j_gnt_s) begin
      last_d    = LAST_J;
      rd_addr_d = bus.j_addr;
    end else begin
      last_d    = last_q;
      rd_addr_d = rd_addr_q;
    end

    tag_valid_d = rd_gnt_s;
    tag_who_d   = j_gnt_s ? LAST_J : LAST_S;
  end

  // Arbitration state and read-return tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= LAST_S;
      starve_q    <= 4'd0;
      rd_addr_q   <= '0;
      tag_valid_q <= 1'b0;
      tag_who_q   <= LAST_S;
    end else begin
      last_q      <= last_d;
      starve_q    <= starve_d;
      rd_addr_q   <= rd_addr_d;
      tag_valid_q <= tag_valid_d;
      tag_who_q   <= tag_who_d;
    end
  end

`ifdef BOARD_ARB_FWD_EN
  logic                 fwd_q, fwd_d;
  logic [DATA_BITS-1:0] fwd_data_q, fwd_data_d;

  // Capture write data that collides with this cycle's granted read.
  always_comb begin
    fwd_d      = rd_gnt_s & we_s & (wr_addr_s == rd_addr_d);
    fwd_data_d = wr_data_s;
  end

  // Forwarding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rd_src_s = fwd_q ? fwd_data_q : bus.ram_rd_data;
`else
  assign rd_src_s = bus.ram_rd_data;
`endif

  assign bus.c_gnt       = c_gnt_s;
  assign bus.m_gnt       = m_gnt_s;
  assign bus.ram_we      = we_s;
  assign bus.ram_wr_addr = wr_addr_s;
  assign bus.ram_wr_data = wr_data_s;

  assign bus.s_gnt       = s_gnt_s;
  assign bus.j_gnt       = j_gnt_s;
  assign bus.ram_rd_addr = rd_addr_d;
  assign bus.starve_cnt  = starve_q;

  assign bus.s_rvalid    = tag_valid_q & (tag_who_q == LAST_S);
  assign bus.j_rvalid    = tag_valid_q & (tag_who_q == LAST_J);
  assign bus.s_rdata     = bus.s_rvalid ? rd_src_s : '0;
  assign bus.j_rdata     = bus.j_rvalid ? rd_src_s : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural model; honours BOARD_ARB_FWD_EN.
module tb_board_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  board_ram_arbiter_if #(.ADDR_BITS(6), .DATA_BITS(2)) ia ();
  board_ram_arbiter_if #(.ADDR_BITS(6), .DATA_BITS(2)) ib ();

  board_ram_arbiter #(.ADDR_BITS(6), .DATA_BITS(2), .JUDGER_PRIO(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  board_ram_arbiter #(.ADDR_BITS(6), .DATA_BITS(2), .JUDGER_PRIO(0), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  // Behavioural RAM: synchronous read, read-before-write.
  logic [1:0] mem_a [64] = '{default: 2'b00};
  logic [1:0] rd_a = 2'b00;
  always @(posedge clk) begin
    rd_a <= mem_a[ia.ram_rd_addr];
    if (ia.ram_we) mem_a[ia.ram_wr_addr] <= ia.ram_wr_data;
  end
  assign ia.ram_rd_data = rd_a;
  assign ib.ram_rd_data = 2'b00;

`ifdef BOARD_ARB_FWD_EN
  localparam logic [1:0] HAZ_EXP = 2'b01;
`else
  localparam logic [1:0] HAZ_EXP = 2'b00;
`endif

  typedef struct {
    logic s_req; logic [5:0] s_addr; logic j_req; logic [5:0] j_addr;
    logic c_req; logic [5:0] c_addr; logic [1:0] c_data;
    logic m_req; logic [5:0] m_addr; logic [1:0] m_data;
    logic e_s; logic e_j; logic e_c; logic e_m;
    logic [5:0] e_waddr; logic [1:0] e_wdata; logic [5:0] e_raddr;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(input logic sr, input int sa, input logic jr, input int ja,
                              input logic cr, input int ca, input int cd,
                              input logic mr, input int ma, input int md,
                              input logic es, input logic ej, input logic ec, input logic em,
                              input int wa, input int wd, input int ra);
    vec_t v;
    v.s_req = sr; v.s_addr = 6'(sa); v.j_req = jr; v.j_addr = 6'(ja);
    v.c_req = cr; v.c_addr = 6'(ca); v.c_data = 2'(cd);
    v.m_req = mr; v.m_addr = 6'(ma); v.m_data = 2'(md);
    v.e_s = es; v.e_j = ej; v.e_c = ec; v.e_m = em;
    v.e_waddr = 6'(wa); v.e_wdata = 2'(wd); v.e_raddr = 6'(ra);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_a();
    ia.s_req = 1'b0; ia.s_addr = 6'd0; ia.j_req = 1'b0; ia.j_addr = 6'd0;
    ia.c_req = 1'b0; ia.c_addr = 6'd0; ia.c_data = 2'd0;
    ia.m_req = 1'b0; ia.m_addr = 6'd0; ia.m_data = 2'd0;
  endtask

  task automatic idle_b();
    ib.s_req = 1'b0; ib.s_addr = 6'd0; ib.j_req = 1'b0; ib.j_addr = 6'd0;
    ib.c_req = 1'b0; ib.c_addr = 6'd0; ib.c_data = 2'd0;
    ib.m_req = 1'b0; ib.m_addr = 6'd0; ib.m_data = 2'd0;
  endtask

  // Random-phase model state and outstanding client requests.
  int         denied;
  logic       pv, pwho;
  logic [1:0] pdata;
  logic [1:0] shadow [16];
  logic [5:0] hold_addr;
  logic       s_on, j_on, c_on, m_on;
  logic [5:0] s_a, j_a, c_a, m_a;
  logic [1:0] c_d, m_d;

  initial begin
    logic       e_s, e_j, e_c, e_m, e_we;
    logic [5:0] e_wa, e_ra;
    logic [1:0] e_wd, rdv;

    vt[0] = mk(0, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    vt[1] = mk(0, 0,  1, 27, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0,  0, 0, 27);
    vt[2] = mk(1, 9,  1, 27, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0,  0, 0, 27);
    vt[3] = mk(1, 63, 0, 0,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0,  0, 0, 63);
    vt[4] = mk(1, 9,  0, 0,  1, 12, 2, 1, 5, 1,   0, 0, 1, 0,  12, 2, 0);
    vt[5] = mk(1, 5,  0, 0,  0, 0, 0,  1, 5, 1,   1, 0, 0, 1,  5, 1, 5);
    vt[6] = mk(0, 0,  0, 0,  1, 0, 0,  0, 0, 0,   0, 0, 1, 0,  0, 0, 0);
    vt[7] = mk(0, 0,  1, 40, 0, 0, 0,  1, 63, 3,  0, 1, 0, 1,  63, 3, 40);
    vt[8] = mk(1, 20, 1, 21, 1, 33, 1, 0, 0, 0,   0, 0, 1, 0,  33, 1, 0);

    idle_a(); idle_b();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle.
    @(negedge clk); #1;
    chk("rst_s_gnt", 32'(ia.s_gnt), 32'd0);
    chk("rst_j_gnt", 32'(ia.j_gnt), 32'd0);
    chk("rst_s_rvalid", 32'(ia.s_rvalid), 32'd0);
    chk("rst_j_rvalid", 32'(ia.j_rvalid), 32'd0);
    chk("rst_rdata", 32'({ia.s_rdata, ia.j_rdata}), 32'd0);
    chk("rst_starve", 32'(ia.starve_cnt), 32'd0);
    chk("rst_ram_we", 32'(ia.ram_we), 32'd0);
    chk("rst_rd_addr", 32'(ia.ram_rd_addr), 32'd0);

    // Single read: write cell 27 = 10 then read it back through the judger.
    @(negedge clk);
    ia.m_req = 1'b1; ia.m_addr = 6'd27; ia.m_data = 2'b10;
    #1 chk("pre_m_gnt", 32'(ia.m_gnt), 32'd1);
    @(negedge clk);
    idle_a(); ia.j_req = 1'b1; ia.j_addr = 6'd27;
    #1 chk("rd_j_gnt", 32'(ia.j_gnt), 32'd1);
    chk("rd_addr27", 32'(ia.ram_rd_addr), 32'd27);
    @(negedge clk);
    idle_a();
    #1 chk("rd_j_rvalid", 32'(ia.j_rvalid), 32'd1);
    chk("rd_j_rdata", 32'(ia.j_rdata), 32'd2);
    chk("rd_s_rvalid", 32'(ia.s_rvalid), 32'd0);
    chk("rd_s_rdata", 32'(ia.s_rdata), 32'd0);

    // Table of single-cycle arbitration vectors, idle cycle between each.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      ia.s_req = vt[k].s_req; ia.s_addr = vt[k].s_addr;
      ia.j_req = vt[k].j_req; ia.j_addr = vt[k].j_addr;
      ia.c_req = vt[k].c_req; ia.c_addr = vt[k].c_addr; ia.c_data = vt[k].c_data;
      ia.m_req = vt[k].m_req; ia.m_addr = vt[k].m_addr; ia.m_data = vt[k].m_data;
      #1;
      chk($sformatf("vec%0d_s_gnt", k), 32'(ia.s_gnt), 32'(vt[k].e_s));
      chk($sformatf("vec%0d_j_gnt", k), 32'(ia.j_gnt), 32'(vt[k].e_j));
      chk($sformatf("vec%0d_c_gnt", k), 32'(ia.c_gnt), 32'(vt[k].e_c));
      chk($sformatf("vec%0d_m_gnt", k), 32'(ia.m_gnt), 32'(vt[k].e_m));
      chk($sformatf("vec%0d_we", k), 32'(ia.ram_we), 32'(vt[k].e_c | vt[k].e_m));
      chk($sformatf("vec%0d_waddr", k), 32'(ia.ram_wr_addr), 32'(vt[k].e_waddr));
      chk($sformatf("vec%0d_wdata", k), 32'(ia.ram_wr_data), 32'(vt[k].e_wdata));
      if (vt[k].e_s || vt[k].e_j) chk($sformatf("vec%0d_raddr", k), 32'(ia.ram_rd_addr), 32'(vt[k].e_raddr));
      @(negedge clk);
      idle_a();
    end

    // Starvation: both readers held, scanner forced every fifth cycle.
    @(negedge clk);
    ia.s_req = 1'b1; ia.s_addr = 6'd1; ia.j_req = 1'b1; ia.j_addr = 6'd2;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve%0d_s_gnt", k), 32'(ia.s_gnt), 32'((k % 5) == 4));
      chk($sformatf("starve%0d_j_gnt", k), 32'(ia.j_gnt), 32'((k % 5) != 4));
      chk($sformatf("starve%0d_cnt", k), 32'(ia.starve_cnt), 32'(k % 5));
      @(negedge clk);
    end
    idle_a();

    // Round-robin instance: J first after reset, then alternating; lone requester always wins.
    ib.s_req = 1'b1; ib.s_addr = 6'd3; ib.j_req = 1'b1; ib.j_addr = 6'd4;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_j_gnt", k), 32'(ib.j_gnt), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_s_gnt", k), 32'(ib.s_gnt), 32'((k % 2) == 1));
      chk($sformatf("rr%0d_starve", k), 32'(ib.starve_cnt), 32'd0);
      @(negedge clk);
    end
    ib.j_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("rr_solo%0d_s_gnt", k), 32'(ib.s_gnt), 32'd1);
      @(negedge clk);
    end
    idle_b();

    // Clear priority: clear wipes the board while move write and scanner wait.
    ia.m_req = 1'b1; ia.m_addr = 6'd7; ia.m_data = 2'b01;
    ia.s_req = 1'b1; ia.s_addr = 6'd8;
    for (int k = 0; k < 64; k++) begin
      ia.c_req = 1'b1; ia.c_addr = 6'(k); ia.c_data = 2'b00;
      #1;
      chk($sformatf("clr%0d_c_gnt", k), 32'(ia.c_gnt), 32'd1);
      chk($sformatf("clr%0d_m_s_gnt", k), 32'({ia.m_gnt, ia.s_gnt}), 32'd0);
      @(negedge clk);
    end
    ia.c_req = 1'b0;
    #1;
    chk("clr_starve_sat", 32'(ia.starve_cnt), 32'd15);
    chk("clr_rel_m_gnt", 32'(ia.m_gnt), 32'd1);
    chk("clr_rel_s_gnt", 32'(ia.s_gnt), 32'd1);
    @(negedge clk);
    idle_a();

    // Same-cycle hazard on cell 5 (cleared to 00 above).
    @(negedge clk);
    ia.m_req = 1'b1; ia.m_addr = 6'd5; ia.m_data = 2'b01;
    ia.s_req = 1'b1; ia.s_addr = 6'd5;
    #1 chk("haz_gnts", 32'({ia.m_gnt, ia.s_gnt}), 32'd3);
    @(negedge clk);
    idle_a();
    #1 chk("haz_s_rvalid", 32'(ia.s_rvalid), 32'd1);
    chk("haz_s_rdata", 32'(ia.s_rdata), 32'(HAZ_EXP));

    // Reset during a grant: the pending return must never appear.
    @(negedge clk);
    ia.j_req = 1'b1; ia.j_addr = 6'd5;
    #1 chk("rstmid_j_gnt", 32'(ia.j_gnt), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    idle_a();
    #1 chk("rstmid_j_rvalid", 32'(ia.j_rvalid), 32'd0);
    chk("rstmid_j_rdata", 32'(ia.j_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rstmid_after_j_rvalid", 32'(ia.j_rvalid), 32'd0);

    // Known board contents for the random phase.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ia.c_req = 1'b1; ia.c_addr = 6'(k); ia.c_data = 2'b00;
      #1 chk($sformatf("init%0d_c_gnt", k), 32'(ia.c_gnt), 32'd1);
      shadow[k] = 2'b00;
    end
    @(negedge clk);
    idle_a();

    // Randomized traffic against the model.
    denied = 0; pv = 1'b0; pwho = 1'b0; pdata = 2'b00; hold_addr = 6'd0;
    s_on = 1'b0; j_on = 1'b0; c_on = 1'b0; m_on = 1'b0;
    s_a = 6'd0; j_a = 6'd0; c_a = 6'd0; m_a = 6'd0; c_d = 2'd0; m_d = 2'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!s_on && $urandom_range(0, 1) == 1) begin s_on = 1'b1; s_a = 6'($urandom_range(0, 15)); end
      if (!j_on && $urandom_range(0, 1) == 1) begin j_on = 1'b1; j_a = 6'($urandom_range(0, 15)); end
      if (!m_on && $urandom_range(0, 2) == 0) begin
        m_on = 1'b1; m_a = 6'($urandom_range(0, 15)); m_d = 2'($urandom_range(0, 3));
      end
      if (!c_on && $urandom_range(0, 7) == 0) begin
        c_on = 1'b1; c_a = 6'($urandom_range(0, 15)); c_d = 2'($urandom_range(0, 3));
      end
      ia.s_req = s_on; ia.s_addr = s_a; ia.j_req = j_on; ia.j_addr = j_a;
      ia.c_req = c_on; ia.c_addr = c_a; ia.c_data = c_d;
      ia.m_req = m_on; ia.m_addr = m_a; ia.m_data = m_d;
      #1;
      e_c = c_on;
      e_m = m_on && !c_on;
      e_s = 1'b0; e_j = 1'b0;
      if (!c_on) begin
        if (s_on && (denied >= 4 || !j_on)) e_s = 1'b1;
        else if (j_on) e_j = 1'b1;
      end
      e_we = e_c || e_m;
      e_wa = e_c ? c_a : (e_m ? m_a : 6'd0);
      e_wd = e_c ? c_d : (e_m ? m_d : 2'd0);
      e_ra = e_s ? s_a : (e_j ? j_a : hold_addr);

      chk("rnd_s_gnt", 32'(ia.s_gnt), 32'(e_s));
      chk("rnd_j_gnt", 32'(ia.j_gnt), 32'(e_j));
      chk("rnd_c_gnt", 32'(ia.c_gnt), 32'(e_c));
      chk("rnd_m_gnt", 32'(ia.m_gnt), 32'(e_m));
      chk("rnd_we", 32'(ia.ram_we), 32'(e_we));
      chk("rnd_waddr", 32'(ia.ram_wr_addr), 32'(e_wa));
      chk("rnd_wdata", 32'(ia.ram_wr_data), 32'(e_wd));
      chk("rnd_raddr", 32'(ia.ram_rd_addr), 32'(e_ra));
      chk("rnd_starve", 32'(ia.starve_cnt), 32'(denied));
      chk("rnd_s_rvalid", 32'(ia.s_rvalid), 32'(pv && !pwho));
      chk("rnd_j_rvalid", 32'(ia.j_rvalid), 32'(pv && pwho));
      chk("rnd_s_rdata", 32'(ia.s_rdata), 32'((pv && !pwho) ? pdata : 2'd0));
      chk("rnd_j_rdata", 32'(ia.j_rdata), 32'((pv && pwho) ? pdata : 2'd0));

      rdv = shadow[e_ra[3:0]];
`ifdef BOARD_ARB_FWD_EN
      if (e_we && (e_wa == e_ra)) rdv = e_wd;
`endif
      pv = e_s || e_j;
      pwho = e_j;
      pdata = rdv;
      hold_addr = e_ra;
      if (e_we) shadow[e_wa[3:0]] = e_wd;
      denied = (s_on && !e_s) ? ((denied < 15) ? denied + 1 : 15) : 0;
      if (e_s) s_on = 1'b0;
      if (e_j) j_on = 1'b0;
      if (e_c) c_on = 1'b0;
      if (e_m) m_on = 1'b0;
      @(negedge clk);
    end
    idle_a();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
